pwm_decoder: RTL and testbench
==============================

Name: pwm_decoder

Overview:
- Receive-side counterpart of the ramp/comparator temperature-to-PWM path.
- Samples the asynchronous comparator PWM output, filters it, and measures high time and period between consecutive rising edges.
- Presents an 8-bit temperature code, with a period measurement and status flags, to the digital core.

Parameters:
- W, 8: code width; the nominal PWM period is 2^W clocks.
- SYNC_STAGES, 2: synchronizer depth for pwm_in (minimum 2).
- FILT, 2: consecutive equal synchronized samples required before the filtered level changes (minimum 1).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- en  input  1  measurement enable
- pwm_in  input  1  comparator PWM output; asynchronous to clk
- code  output  W  high-time count of last complete period, saturated
- period  output  W+1  clock count of last complete period
- valid  output  1  one-cycle pulse when code and period update
- sat  output  1  last high count exceeded 2^W-1
- stuck_hi  output  1  no rising edge within timeout, input high
- stuck_lo  output  1  no rising edge within timeout, input low

Behaviour:
- Reset (reset=0, async): all flops 0, including synchronizer, filter, counters, state and every output. The filtered level resets to 0. Release is synchronous to clk.
- Synchronizer: SYNC_STAGES flops on pwm_in.
- Filter: counter of consecutive synchronized samples differing from the filtered level. When it reaches FILT, the filtered level toggles and the counter clears; any agreeing sample clears it. Pulses shorter than FILT cycles are ignored. Both edges see equal delay (SYNC_STAGES+FILT), so duty is preserved.
- rise: a one-cycle strobe when the filtered level goes 0->1.
- FSM states: IDLE, ARM, MEAS.
- IDLE:
  - en=1 -> ARM.
  - Counters held at 0.
- ARM:
  - On rise -> MEAS, with per_cnt=1 and hi_cnt=1.
  - en=0 -> IDLE.
- MEAS (each cycle without rise): per_cnt+=1; hi_cnt+=1 if filtered=1. Both counters are W+1 bits.
- MEAS on rise:
  - period <= per_cnt.
  - code <= min(hi_cnt, 2^W-1); sat <= (hi_cnt > 2^W-1).
  - valid=1 for that one cycle.
  - stuck_hi and stuck_lo cleared.
  - Counters restart at per_cnt=1, hi_cnt=1; stay in MEAS.
- Timeout in MEAS or ARM:
  - Trigger: per_cnt reaches 2^(W+1)-1 without rise (ARM uses the same counter, running).
  - stuck_hi <= filtered and stuck_lo <= ~filtered.
  - No valid. Go to ARM with counters cleared.
- en=0 in any state: IDLE next cycle, counters cleared, no valid pulse. code, period, sat and stuck flags hold their last values.
- rise and timeout in the same cycle: rise wins.
- en falling in the same cycle as rise: no valid.
- Outputs are registered; valid appears the cycle after the terminating filtered rise is sampled.

Test Plan:
- Period and high-time measurement: en=1, PWM period 256 clocks, high 64, three periods -> valid once per 256 cycles from the second rise onward; code=64, period=256, sat=0.
- Glitch rejection: same waveform plus a 1-cycle high glitch mid-low phase, FILT=2 -> code=64, period=256, no extra valid.
- Saturation: period 300, high 280 -> code=255, sat=1, period=300.
- Stuck input: pwm_in held high after one rise -> stuck_hi=1 after 511 cycles of MEAS, no valid. A subsequent 256/128 waveform -> stuck_hi clears on the next valid; code=128.
- Disable mid-measure: en dropped 100 cycles into a period -> no valid. Re-enable -> first valid only after two fresh rises; code and period correct.
- Reset mid-operation: reset asserted mid-period -> all outputs 0 immediately. After release with en=1, the first valid carries a correct measurement of a full period.

Source files
------------

// File: rtl/pwm_decoder.sv
// PWM receiver: synchronizes and deglitches an asynchronous comparator PWM, then measures
// high time and rising-edge-to-rising-edge period, with stuck-input detection.
module pwm_decoder #(
    parameter int W           = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILT        = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         pwm_in,
    output logic [W-1:0] code,
    output logic [W:0]   period,
    output logic         valid,
    output logic         sat,
    output logic         stuck_hi,
    output logic         stuck_lo,
    output logic [1:0]   state_dbg
);
    // valid is a one-cycle strobe with no back-pressure: code/period/sat are stable from
    // the valid cycle until the next valid, and the consumer must take them when valid=1.
    localparam int       FW       = (FILT < 2) ? 1 : $clog2(FILT + 1);
    localparam logic [W:0] PER_MAX  = '1;
    localparam logic [W:0] CODE_MAX = {1'b0, {W{1'b1}}};
    localparam logic [W:0] ONE      = {{W{1'b0}}, 1'b1};
    localparam logic [FW-1:0] FILT_LAST = FW'(FILT - 1);
    localparam logic [FW-1:0] FONE      = {{(FW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [FW-1:0]          filt_cnt;
    logic                   filtered;
    logic                   filt_d;
    logic [W:0]             per_cnt;
    logic [W:0]             hi_cnt;
    logic                   sample;
    logic                   rise;

    assign sample    = sync_q[SYNC_STAGES-1];
    assign rise      = filtered & ~filt_d;
    assign state_dbg = state;

    // Both edges need FILT agreeing samples, so high and low phases see the same delay.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q   <= '0;
            filt_cnt <= '0;
            filtered <= 1'b0;
            filt_d   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            filt_d <= filtered;
            if (sample != filtered) begin
                if (filt_cnt == FILT_LAST) begin
                    filtered <= ~filtered;
                    filt_cnt <= '0;
                end else begin
                    filt_cnt <= filt_cnt + FONE;
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            per_cnt  <= '0;
            hi_cnt   <= '0;
            code     <= '0;
            period   <= '0;
            valid    <= 1'b0;
            sat      <= 1'b0;
            stuck_hi <= 1'b0;
            stuck_lo <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (!en) begin
                state   <= IDLE;
                per_cnt <= '0;
                hi_cnt  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state   <= ARM;
                        per_cnt <= '0;
                        hi_cnt  <= '0;
                    end
                    ARM: begin
                        if (rise) begin
                            state   <= MEAS;
                            per_cnt <= ONE;
                            hi_cnt  <= ONE;
                        end else if (per_cnt == PER_MAX) begin
                            stuck_hi <= filtered;
                            stuck_lo <= ~filtered;
                            per_cnt  <= '0;
                            hi_cnt   <= '0;
                        end else begin
                            per_cnt <= per_cnt + ONE;
                        end
                    end
                    MEAS: begin
                        // A rise on the timeout cycle still closes a valid period.
                        if (rise) begin
                            period   <= per_cnt;
                            code     <= (hi_cnt > CODE_MAX) ? '1 : hi_cnt[W-1:0];
                            sat      <= (hi_cnt > CODE_MAX);
                            valid    <= 1'b1;
                            stuck_hi <= 1'b0;
                            stuck_lo <= 1'b0;
                            per_cnt  <= ONE;
                            hi_cnt   <= ONE;
                        end else if (per_cnt == PER_MAX) begin
                            stuck_hi <= filtered;
                            stuck_lo <= ~filtered;
                            state    <= ARM;
                            per_cnt  <= '0;
                            hi_cnt   <= '0;
                        end else begin
                            per_cnt <= per_cnt + ONE;
                            hi_cnt  <= hi_cnt + {{W{1'b0}}, filtered};
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        per_cnt <= '0;
                        hi_cnt  <= '0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pwm_decoder.sv
// Randomized scoreboard bench for pwm_decoder: the model derives each expected measurement
// directly from the high/low phase lengths it drives onto pwm_in.
module tb_pwm_decoder;
    logic       clk;
    logic       reset;
    logic       en;
    logic       pwm_in;
    logic [7:0] code;
    logic [8:0] period;
    logic       valid;
    logic       sat;
    logic       stuck_hi;
    logic       stuck_lo;
    logic [1:0] state_dbg;

    int tests_run = 0;
    int tests_failed = 0;

    logic [17:0] exp_q[$];
    bit armed = 0;
    bit have_prev = 0;
    int cur_hi = 0;
    int cur_per = 0;

    pwm_decoder #(.W(8), .SYNC_STAGES(2), .FILT(2)) dut (
        .clk(clk), .reset(reset), .en(en), .pwm_in(pwm_in),
        .code(code), .period(period), .valid(valid), .sat(sat),
        .stuck_hi(stuck_hi), .stuck_lo(stuck_lo), .state_dbg(state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, queue depth %0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // A period of hi high cycles out of per total cycles, as the decoder should report it.
    task automatic push_exp(input int hi, input int per);
        logic       s;
        logic [7:0] c;
        logic [8:0] p;
        s = (hi > 255);
        c = s ? 8'd255 : hi[7:0];
        p = per[8:0];
        exp_q.push_back({s, c, p});
    endtask

    // driver tasks
    task automatic drive(input logic lvl, input int n);
        for (int i = 0; i < n; i++) begin
            pwm_in = lvl;
            @(negedge clk);
        end
    endtask

    task automatic phase_high(input int n);
        if (armed && have_prev) push_exp(cur_hi, cur_per);
        have_prev = armed;
        cur_hi = n;
        cur_per = n;
        drive(1'b1, n);
    endtask

    task automatic phase_low(input int n);
        cur_per += n;
        drive(1'b0, n);
    endtask

    task automatic glitch_high();
        cur_per += 1;
        drive(1'b1, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_code"}, 32'(code), 0);
        check({tag, "_period"}, 32'(period), 0);
        check({tag, "_valid"}, 32'(valid), 0);
        check({tag, "_sat"}, 32'(sat), 0);
        check({tag, "_stuck_hi"}, 32'(stuck_hi), 0);
        check({tag, "_stuck_lo"}, 32'(stuck_lo), 0);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (reset && valid) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL spurious_valid: got valid with code %0d period %0d, expected no valid at %0t",
                         code, period, $time);
            end else begin
                logic [17:0] e;
                e = exp_q.pop_front();
                check("meas_code", 32'(code), 32'(e[16:9]));
                check("meas_period", 32'(period), 32'(e[8:0]));
                check("meas_sat", 32'(sat), 32'(e[17]));
                check("meas_stuck_hi", 32'(stuck_hi), 0);
                check("meas_stuck_lo", 32'(stuck_lo), 0);
            end
        end
    end

    initial begin
        int per, hi, lo, la;
        reset = 1'b0;
        en = 1'b0;
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;
        @(negedge clk);

        // input held low while armed: ARM timeout flags stuck_lo
        en = 1'b1;
        armed = 1;
        have_prev = 0;
        drive(1'b0, 530);
        check("stuck_lo_set", 32'(stuck_lo), 1);
        check("stuck_lo_hi_clear", 32'(stuck_hi), 0);

        // nominal 256-cycle period, 64 high
        for (int i = 0; i < 4; i++) begin
            phase_high(64);
            phase_low(192);
        end

        // single-cycle glitch in the low phase must not register
        phase_high(64);
        phase_low(90);
        glitch_high();
        phase_low(101);

        // saturation: 280 high in a 300 period
        phase_high(280);
        phase_low(20);
        phase_high(280);
        phase_low(20);

        // stuck high: timeout in MEAS, then recovery on a 256/128 waveform
        phase_high(600);
        have_prev = 0;
        check("stuck_hi_set", 32'(stuck_hi), 1);
        check("stuck_hi_lo_clear", 32'(stuck_lo), 0);
        phase_low(128);
        phase_high(128);
        phase_low(128);
        check("stuck_hi_holds_until_valid", 32'(stuck_hi), 1);
        phase_high(128);
        phase_low(128);

        // disable 100 cycles into a period, re-enable in a later low phase
        phase_high(64);
        phase_low(36);
        en = 1'b0;
        armed = 0;
        have_prev = 0;
        phase_low(156);
        phase_high(64);
        phase_low(100);
        en = 1'b1;
        armed = 1;
        phase_low(92);
        phase_high(64);
        phase_low(192);
        phase_high(64);
        phase_low(192);

        // asynchronous reset mid-period, released during a low phase
        phase_high(30);
        #2 reset = 1'b0;
        #1 check_all_zero("async_reset");
        have_prev = 0;
        drive(1'b1, 34);
        drive(1'b0, 100);
        reset = 1'b1;
        drive(1'b0, 92);
        phase_high(100);
        phase_low(150);
        phase_high(77);
        phase_low(50);

        // randomized periods, some with a rejected glitch
        for (int i = 0; i < 24; i++) begin
            per = $urandom_range(500, 8);
            hi = $urandom_range(per - 5, 3);
            lo = per - hi;
            phase_high(hi);
            if (lo >= 10 && $urandom_range(1, 0) == 1) begin
                la = $urandom_range(lo - 5, 4);
                phase_low(la);
                glitch_high();
                phase_low(lo - 1 - la);
            end else begin
                phase_low(lo);
            end
        end
        phase_high(50);
        phase_low(50);

        drive(1'b0, 20);
        check("queue_drained", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
